alu_inst_decoder: RTL
=====================

Name: alu_inst_decoder

Overview:
- Decodes a stream of 32-bit RV64I integer ALU instructions into the ALU control bundle: func3, func7, shamt, immediate, operand select and register indices.
- Sits between instruction fetch and the 64-bit ALU, and is the producer of the ALU's func3/func7/shamt encoding.
- Registered output stage plus a one-entry skid buffer, with valid/ready on both sides.
- Flags illegal encodings and keeps saturating decode statistics.

Parameters:
XLEN, 64, data width of the sign-extended immediate
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction valid
in_ready  out  1  decoder can accept an instruction
in_instr  in  32  raw instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  consumer accepts bundle
out_func3  out  3  ALU func3
out_func7  out  7  ALU func7
out_shamt  out  6  ALU shift amount
out_imm  out  XLEN  sign-extended I-immediate
out_use_imm  out  1  1 = B operand is out_imm, 0 = rs2
out_is_word  out  1  OP-32/OP-IMM-32 (W-form)
out_is_cmp  out  1  func3 is 010 or 011 (consumer samples Comparison)
out_rd  out  5  destination register
out_rs1  out  5  source 1
out_rs2  out  5  source 2 (0 when use_imm)
out_illegal  out  1  encoding not a legal ALU instruction
cnt_decoded  out  CNT_W  bundles handed off, saturating
cnt_illegal  out  CNT_W  illegal bundles handed off, saturating

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - Clears out_valid, the skid entry, both counters and all out_* data fields to 0.
  - in_ready = !skid_valid, so it reads 1 from the first cycle after reset.
  - Reset mid-transfer discards both held entries without emitting them.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
  - Throughput is 1 per cycle while out_ready=1.
- Storage and flow control:
  - Output register plus one skid entry.
  - If the output is held (out_valid & !out_ready) and an input is accepted, the decoded input goes to the skid entry and in_ready falls next cycle.
  - When the output transfers, the skid entry, if valid, moves to the output register. Otherwise a simultaneous input goes directly to the output register.
  - Order is preserved, with no loss or duplication.
  - Outputs are stable while out_valid & !out_ready.
- Decode (opcode = instr[6:0]; rd, rs1, rs2 and func3 from the standard fields):
  - 0110011 OP:
    - func7 = instr[31:25]; use_imm=0.
    - Legal if func7 = 0000000, or func7 = 0100000 with func3 in {000, 101}.
    - shamt = 0.
  - 0010011 OP-IMM:
    - use_imm=1; imm = sign-extend instr[31:20]; rs2=0.
    - func3 001 requires instr[31:26] = 000000.
    - func3 101 requires instr[31:26] in {000000, 010000}.
    - For 001/101: shamt = instr[25:20], func7 = {instr[31:26], 1'b0}.
    - For other func3: func7 = 0, shamt = 0.
  - 0111011 OP-32 / 0011011 OP-IMM-32:
    - Same rules as the 64-bit forms, with is_word=1.
    - OP-32 allows func3 in {000, 001, 101} only.
    - OP-IMM-32 allows func3 in {000, 001, 101} only.
    - Shifts additionally require instr[25] = 0.
  - Any other opcode or violation sets illegal=1 and forces every other data field (func3, func7, shamt, imm, use_imm, is_word, is_cmp, rd, rs1, rs2) to 0.
- Counters:
  - Increment on each output transfer; cnt_illegal increments only when out_illegal=1.
  - Both saturate at all-ones and never wrap.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants (OP, OP_IMM, OP_32, OP_IMM_32)
  - func3 constants (ADD_SUB, SLL, SLT, SLTU, XOR, SRL_SRA, OR, AND)
  - FUNC7_BASE = 0000000, FUNC7_ALT = 0100000
  - a packed alu_ctrl_t struct for the output bundle
- Sub-module alu_decode_comb: purely combinational instr -> alu_ctrl_t. The top holds the skid/output registers and the counters.

Test Plan:
- Reset then 0x002081B3 (ADD x3,x1,x2) with out_ready=1 -> next cycle out_valid=1, func3=000, func7=0000000, rd=3, rs1=1, rs2=2, use_imm=0, illegal=0.
- 0x402081B3 (SUB), then 0x40435293 (SRAI x5,x6,4) back-to-back -> func7=0100000 on both outputs; SRAI gives func3=101, shamt=4, use_imm=1, rs2=0.
- 0xFFF00093 (ADDI x1,x0,-1) -> imm=0xFFFFFFFFFFFFFFFF, func3=000, func7=0.
- 0x00000000 and 0x44435293 (bad SRAI upper bits) -> illegal=1 with all other fields 0; cnt_illegal=2 and cnt_decoded=2 after both transfers.
- Stream 3 instructions with out_ready=0 for 3 cycles -> in_ready=0 after the 2nd is accepted; release gives all 3 in order, unchanged while stalled.
- Assert rst with both entries full -> next cycle out_valid=0, in_ready=1, counters 0; the held instructions are never emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings and the decoded control bundle for the RV64I integer ALU path.
package alu_pkg;

    localparam int ALU_XLEN = 64;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

    localparam logic [2:0] ADD_SUB = 3'b000;
    localparam logic [2:0] SLL     = 3'b001;
    localparam logic [2:0] SLT     = 3'b010;
    localparam logic [2:0] SLTU    = 3'b011;
    localparam logic [2:0] XOR     = 3'b100;
    localparam logic [2:0] SRL_SRA = 3'b101;
    localparam logic [2:0] OR      = 3'b110;
    localparam logic [2:0] AND     = 3'b111;

    localparam logic [6:0] FUNC7_BASE = 7'b0000000;
    localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

    typedef struct packed {
        logic                illegal;
        logic [2:0]          func3;
        logic [6:0]          func7;
        logic [5:0]          shamt;
        logic [ALU_XLEN-1:0] imm;
        logic                use_imm;
        logic                is_word;
        logic                is_cmp;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
    } alu_ctrl_t;

    // W-form instructions only exist for add/sub and the shifts.
    function automatic logic word_func3_ok(input logic [2:0] f3);
        return (f3 == ADD_SUB) || (f3 == SLL) || (f3 == SRL_SRA);
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational decode of one 32-bit instruction into the ALU control bundle.
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_ctrl_t   ctrl
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] hi6;
    logic       is_shift;
    logic       legal;
    alu_ctrl_t  d;

    assign opcode   = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign hi6      = instr[31:26];
    assign is_shift = (f3 == SLL) || (f3 == SRL_SRA);

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred;
        // combinational logic uses blocking assignments so later lines see earlier ones.
        d       = '0;
        legal   = 1'b0;
        d.func3 = f3;
        d.rd    = instr[11:7];
        d.rs1   = instr[19:15];
        d.is_cmp = (f3 == SLT) || (f3 == SLTU);

        case (opcode)
            OP, OP_32: begin
                d.func7   = f7;
                d.rs2     = instr[24:20];
                d.is_word = (opcode == OP_32);
                legal = (f7 == FUNC7_BASE) ||
                        ((f7 == FUNC7_ALT) && ((f3 == ADD_SUB) || (f3 == SRL_SRA)));
                if (d.is_word) legal = legal && word_func3_ok(f3);
            end
            OP_IMM, OP_IMM_32: begin
                d.use_imm = 1'b1;
                d.imm     = {{(ALU_XLEN-12){instr[31]}}, instr[31:20]};
                d.is_word = (opcode == OP_IMM_32);
                if (is_shift) begin
                    d.func7 = {hi6, 1'b0};
                    d.shamt = instr[25:20];
                end
                legal = !is_shift || (hi6 == 6'b000000) ||
                        ((f3 == SRL_SRA) && (hi6 == FUNC7_ALT[6:1]));
                // A 32-bit shift cannot name a shift amount of 32 or more.
                if (d.is_word) legal = legal && word_func3_ok(f3) && !(is_shift && instr[25]);
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            d         = '0;
            d.illegal = 1'b1;
        end
    end

    assign ctrl = d;

endmodule

// File: rtl/alu_inst_decoder.sv
// Registered ALU instruction decoder: output register plus one skid entry, with saturating stats.
module alu_inst_decoder
    import alu_pkg::*;
#(
    parameter int XLEN  = ALU_XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_func3,
    output logic [6:0]       out_func7,
    output logic [5:0]       out_shamt,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_use_imm,
    output logic             out_is_word,
    output logic             out_is_cmp,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_illegal,
    output logic [CNT_W-1:0] cnt_decoded,
    output logic [CNT_W-1:0] cnt_illegal
);

    alu_ctrl_t dec;
    alu_ctrl_t out_q;
    alu_ctrl_t skid_q;
    logic      out_v;
    logic      skid_v;
    logic      in_fire;
    logic      out_fire;

    alu_decode_comb u_decode (
        .instr (in_instr),
        .ctrl  (dec)
    );

    assign in_ready = !skid_v;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_v && out_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (out_fire || !out_v) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else if (in_fire) begin
                out_q <= dec;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_decoded <= '0;
            cnt_illegal <= '0;
        end else if (out_fire) begin
            if (cnt_decoded != '1) cnt_decoded <= cnt_decoded + CNT_W'(1);
            if (out_q.illegal && (cnt_illegal != '1)) cnt_illegal <= cnt_illegal + CNT_W'(1);
        end
    end

    assign out_valid   = out_v;
    assign out_func3   = out_q.func3;
    assign out_func7   = out_q.func7;
    assign out_shamt   = out_q.shamt;
    assign out_imm     = XLEN'($signed(out_q.imm));
    assign out_use_imm = out_q.use_imm;
    assign out_is_word = out_q.is_word;
    assign out_is_cmp  = out_q.is_cmp;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_illegal = out_q.illegal;

endmodule
